key_event_arbiter: RTL and testbench

//  Converts the 16 debounced key levels (active-high pressed) from the key debounce stage into discrete press events.

---
 rtl/key_pkg.sv | 34 +++
 rtl/key_event_arbiter_if.sv | 11 +
 rtl/key_evt_fifo.sv | 62 ++++++
 rtl/key_event_arbiter.sv | 101 ++++++++++
 tb/tb_key_event_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key event path.
// Holds the round-robin search used by the arbiter.
package key_pkg;

    localparam int KEY_N          = 16;
    localparam int KEY_CODE_W     = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [KEY_N-1:0]      key_vec_t;
    typedef logic [KEY_CODE_W-1:0] key_code_t;

    typedef struct packed {
        logic      found;
        key_code_t idx;
    } rr_grant_t;

    // Scan ptr, ptr+1, ... (mod 16); the 4-bit add provides the wrap.
    function automatic rr_grant_t rr_pick(input key_vec_t req, input key_code_t ptr);
        rr_grant_t res;
        key_code_t idx;
        res = '0;
        for (int k = 0; k < KEY_N; k++) begin
            idx = ptr + key_code_t'(k);
            if (!res.found && req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// Key event handshake toward the display/command logic.
interface key_event_arbiter_if;
    import key_pkg::*;

    logic      evt_valid;
    logic      evt_ready;
    key_code_t evt_code;

    modport master (output evt_valid, output evt_code, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_code, output evt_ready);
endinterface

// File: rtl/key_evt_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted when a read
// retires an entry in the same cycle.
module key_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      cnt_r;
    logic             rd_do_s;
    logic             wr_do_s;

    // Qualify read/write strobes against occupancy.
    always_comb begin
        rd_do_s = rd_en & ~empty;
        wr_do_s = wr_en & (~full | rd_do_s);
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (wr_do_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_do_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_do_s, rd_do_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (cnt_r == (AW+1)'(DEPTH));
    assign empty   = (cnt_r == (AW+1)'(0));
    assign count   = cnt_r;

endmodule

// File: rtl/key_event_arbiter.sv
// Turns debounced key levels into press events: rising edges become pending
// requests, a round-robin arbiter moves one per cycle into the event FIFO.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        RSTn,
    input  logic [KEY_N-1:0]            key_deb,
    key_event_arbiter_if.master         evt,
    output logic [KEY_N-1:0]            pend_mask,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        overflow,
    input  logic                        clr_ovf
);
    key_vec_t  key_prev_r;
    key_vec_t  pend_r;
    key_code_t rr_ptr_r;
    logic      ovf_r;

    key_vec_t  rise_s;
    key_vec_t  req_s;
    key_vec_t  gnt_vec_s;
    key_vec_t  pend_nxt_s;
    rr_grant_t grant_s;
    logic      fifo_full_s;
    logic      fifo_empty_s;
    logic      rd_fire_s;
    logic      can_wr_s;
    logic      drop_s;
    key_code_t fifo_data_s;

    // Edge detect, full-aware request gating, grant and pending update.
    always_comb begin
        rise_s    = key_deb & ~key_prev_r;
        rd_fire_s = evt.evt_ready & ~fifo_empty_s;
        can_wr_s  = ~fifo_full_s | rd_fire_s;
        if (can_wr_s) begin
            req_s = pend_r;
        end else begin
            req_s = '0;
        end
        grant_s   = rr_pick(req_s, rr_ptr_r);
        gnt_vec_s = '0;
        if (grant_s.found) begin
            gnt_vec_s[grant_s.idx] = 1'b1;
        end else begin
            gnt_vec_s = '0;
        end
        // A fresh rise on the key being granted re-arms its pending bit.
        pend_nxt_s = (pend_r & ~gnt_vec_s) | rise_s;
        drop_s     = |(pend_r & rise_s & ~gnt_vec_s);
    end

    // Edge history, pending set, round-robin pointer and sticky overflow.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            key_prev_r <= '0;
            pend_r     <= '0;
            rr_ptr_r   <= '0;
            ovf_r      <= 1'b0;
        end else begin
            key_prev_r <= key_deb;
            pend_r     <= pend_nxt_s;
            if (grant_s.found) begin
                rr_ptr_r <= grant_s.idx + key_code_t'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    key_evt_fifo #(
        .WIDTH (KEY_CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .RSTn    (RSTn),
        .wr_en   (grant_s.found),
        .wr_data (grant_s.idx),
        .rd_en   (evt.evt_ready),
        .rd_data (fifo_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_cnt)
    );

    assign evt.evt_valid = ~fifo_empty_s;
    assign evt.evt_code  = fifo_data_s;
    assign pend_mask     = pend_r;
    assign overflow      = ovf_r;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: edge capture, round-robin order,
// full FIFO back-pressure, overflow and reset behaviour.
module tb_key_event_arbiter;
    import key_pkg::*;

    logic        clk;
    logic        RSTn;
    logic [15:0] key_deb;
    logic [15:0] pend_mask;
    logic [2:0]  fifo_cnt;
    logic        overflow;
    logic        clr_ovf;
    int          n_tests;
    int          n_fail;

    key_event_arbiter_if ev ();

    key_event_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .key_deb   (key_deb),
        .evt       (ev),
        .pend_mask (pend_mask),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RSTn = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(ev.evt_valid), 32'd0);
        check_eq({tag, "_code"},  32'(ev.evt_code),  32'd0);
        check_eq({tag, "_cnt"},   32'(fifo_cnt),     32'd0);
        check_eq({tag, "_pend"},  32'(pend_mask),    32'd0);
        check_eq({tag, "_ovf"},   32'(overflow),     32'd0);
    endtask

    initial begin
        logic [3:0] exp_codes [5];
        n_tests      = 0;
        n_fail       = 0;
        RSTn         = 1'b0;
        key_deb      = 16'h0000;
        clr_ovf      = 1'b0;
        ev.evt_ready = 1'b0;
        @(negedge clk);

        // Single press of key 5, held.
        do_reset();
        check_idle("rst");
        key_deb = 16'h0020;
        tick(1);
        check_eq("t1_pend",  32'(pend_mask),    32'h0020);
        check_eq("t1_val0",  32'(ev.evt_valid), 32'd0);
        tick(1);
        check_eq("t1_pend2", 32'(pend_mask),    32'h0000);
        check_eq("t1_valid", 32'(ev.evt_valid), 32'd1);
        check_eq("t1_code",  32'(ev.evt_code),  32'd5);
        tick(3);
        check_eq("t1_hold",  32'(fifo_cnt),     32'd1);
        ev.evt_ready = 1'b1;
        tick(1);
        check_eq("t1_drain", 32'(ev.evt_valid), 32'd0);
        ev.evt_ready = 1'b0;

        // Round-robin order between keys 3 and 12.
        do_reset();
        ev.evt_ready = 1'b1;
        key_deb = 16'h1008;
        tick(2);
        check_eq("t2a_c0", 32'(ev.evt_code), 32'd3);
        tick(1);
        check_eq("t2a_c1", 32'(ev.evt_code), 32'd12);
        tick(1);
        check_eq("t2a_end", 32'(ev.evt_valid), 32'd0);
        key_deb = 16'h0000;
        tick(1);
        key_deb = 16'h1008;
        tick(2);
        check_eq("t2b_c0", 32'(ev.evt_code), 32'd3);
        tick(1);
        check_eq("t2b_c1", 32'(ev.evt_code), 32'd12);
        tick(1);
        key_deb = 16'h0000;
        tick(1);
        key_deb = 16'h0008;
        tick(2);
        check_eq("t2c_c0", 32'(ev.evt_code), 32'd3);
        tick(1);
        key_deb = 16'h0000;
        tick(1);
        key_deb = 16'h1008;
        tick(2);
        check_eq("t2d_c0", 32'(ev.evt_code), 32'd12);
        tick(1);
        check_eq("t2d_c1", 32'(ev.evt_code), 32'd3);
        tick(1);
        check_eq("t2d_end", 32'(ev.evt_valid), 32'd0);
        key_deb = 16'h0000;

        // Six keys against a four-entry FIFO, then drain with back-to-back read/write.
        do_reset();
        ev.evt_ready = 1'b0;
        key_deb = 16'h003F;
        tick(6);
        check_eq("t3_cnt",  32'(fifo_cnt),    32'd4);
        check_eq("t3_pend", 32'(pend_mask),   32'h0030);
        check_eq("t3_head", 32'(ev.evt_code), 32'd0);
        ev.evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t3_code%0d", i), 32'(ev.evt_code), 32'(i));
            tick(1);
            if (i == 0) begin
                check_eq("t5_cnt_full_rw", 32'(fifo_cnt),  32'd4);
                check_eq("t5_pend",        32'(pend_mask), 32'h0020);
            end
        end
        check_eq("t3_empty", 32'(ev.evt_valid), 32'd0);
        check_eq("t3_ovf",   32'(overflow),     32'd0);
        ev.evt_ready = 1'b0;
        key_deb = 16'h0000;

        // Overflow: key 7 re-pressed while still pending behind a full FIFO.
        do_reset();
        key_deb = 16'h000F;
        tick(5);
        check_eq("t4_cnt", 32'(fifo_cnt), 32'd4);
        key_deb = 16'h008F;
        tick(1);
        check_eq("t4_pend", 32'(pend_mask), 32'h0080);
        check_eq("t4_ovf0", 32'(overflow),  32'd0);
        key_deb = 16'h000F;
        tick(1);
        key_deb = 16'h008F;
        tick(1);
        check_eq("t4_ovf1",  32'(overflow),  32'd1);
        check_eq("t4_pend2", 32'(pend_mask), 32'h0080);
        exp_codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
        ev.evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t4_code%0d", i), 32'(ev.evt_code), 32'(exp_codes[i]));
            tick(1);
        end
        check_eq("t4_empty", 32'(ev.evt_valid), 32'd0);
        check_eq("t4_pend3", 32'(pend_mask),    32'h0000);
        ev.evt_ready = 1'b0;
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_eq("t4_clr", 32'(overflow), 32'd0);
        key_deb = 16'h0000;

        // Reset with queued and pending events; held keys re-fire afterwards.
        do_reset();
        key_deb = 16'h001F;
        tick(4);
        check_eq("t6_cnt",  32'(fifo_cnt),  32'd3);
        check_eq("t6_pend", 32'(pend_mask), 32'h0018);
        RSTn = 1'b0;
        #1;
        check_idle("t6_async");
        @(negedge clk);
        RSTn = 1'b1;
        ev.evt_ready = 1'b1;
        tick(1);
        check_eq("t6_repend", 32'(pend_mask), 32'h001F);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t6_code%0d", i), 32'(ev.evt_code), 32'(i));
            tick(1);
        end
        check_eq("t6_empty", 32'(ev.evt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
